// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor z = x - y - bi, one digit per clock, LSD first.
// Define BCD_SUB_SIGN_MAG_EN to return sign-magnitude (extra FIX pass) instead of ten's complement.
module bcd_sub_serial #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   x,
  input  logic [4*DIGITS-1:0]   y,
  input  logic                  bi,
  output logic [4*DIGITS-1:0]   z,
  output logic                  bo,
  output logic                  neg,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

`ifdef BCD_SUB_SIGN_MAG_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
`else
  typedef enum logic {IDLE, RUN} state_e;
`endif

  state_e          state_q, state_d;
  logic [W-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            br_q, br_d, bo_q, bo_d, neg_q, neg_d, err_q, err_d, done_q, done_d;
  logic [3:0]      dig_a, dig_b, dig_z;
  logic [5:0]      diff;
  logic            dig_br;
  logic            last;

  function automatic logic any_bad(input logic [W-1:0] v);
    any_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) any_bad = 1'b1;
  endfunction

  assign last = (cnt_q == LAST);

  // Shared digit datapath; FIX reuses it as 0 - z_i - borrow.
  always_comb begin
    dig_a = x_q[4*cnt_q +: 4];
    dig_b = y_q[4*cnt_q +: 4];
`ifdef BCD_SUB_SIGN_MAG_EN
    if (state_q == FIX) begin
      dig_a = '0;
      dig_b = z_q[4*cnt_q +: 4];
    end
`endif
    diff   = {2'b00, dig_a} - {2'b00, dig_b} - {5'b0, br_q};
    dig_br = diff[5];
    dig_z  = dig_br ? (diff[3:0] + 4'd10) : diff[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: if (last) begin
`ifdef BCD_SUB_SIGN_MAG_EN
        state_d = dig_br ? FIX : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef BCD_SUB_SIGN_MAG_EN
      FIX: if (last) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    bo_d   = bo_q;
    neg_d  = neg_q;
    err_d  = err_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        x_d   = x;
        y_d   = y;
        br_d  = bi;
        cnt_d = '0;
        err_d = any_bad(x) | any_bad(y);
      end
      RUN: begin
        z_d[4*cnt_q +: 4] = dig_z;
        br_d  = dig_br;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
`ifdef BCD_SUB_SIGN_MAG_EN
          if (dig_br) begin
            br_d = 1'b0;
          end else begin
            bo_d   = 1'b0;
            neg_d  = 1'b0;
            done_d = 1'b1;
          end
`else
          bo_d   = dig_br;
          neg_d  = 1'b0;
          done_d = 1'b1;
`endif
        end
      end
`ifdef BCD_SUB_SIGN_MAG_EN
      FIX: begin
        z_d[4*cnt_q +: 4] = dig_z;
        br_d  = dig_br;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          bo_d   = 1'b1;
          neg_d  = 1'b1;
          done_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      bo_q   <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      bo_q   <= bo_d;
      neg_q  <= neg_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    z    = z_q;
    bo   = bo_q;
    neg  = neg_q;
    err  = err_q;
    done = done_q;
  end

endmodule
